// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the CPU load/store path: access sizes,
// LSU controller states and response error codes.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_ILL  = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'b00,
    LSU_READ  = 2'b01,
    LSU_WRITE = 2'b10,
    LSU_RESP  = 2'b11
  } lsu_state_t;

  localparam logic [1:0] LSU_ERR_OK      = 2'b00;
  localparam logic [1:0] LSU_ERR_ALIGN   = 2'b01;
  localparam logic [1:0] LSU_ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores, alignment check, and load extraction with
// zero/sign extension. Purely combinational.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic        load_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = readdata[{addr_lo, 3'b000} +: 8];
  assign half_s = readdata[{addr_lo[1], 4'b0000} +: 16];

  // Per-size lane mapping; the illegal size code is reported as misaligned
  always_comb begin
    byteenable = 4'b0000;
    writedata  = wdata;
    misaligned = 1'b0;
    load_data  = 32'h0000_0000;
    case (size)
      MEM_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        writedata  = {4{wdata[7:0]}};
        load_data  = load_signed ? {{24{byte_s[7]}}, byte_s} : {24'h00_0000, byte_s};
      end
      MEM_HALF: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
        load_data  = load_signed ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
      end
      MEM_WORD: begin
        byteenable = 4'b1111;
        misaligned = (addr_lo != 2'b00);
        load_data  = readdata;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/avalon_lsu_master.sv
// Avalon-MM master for the CPU load/store path: one request at a time,
// registered bus strobes held through waitrequest, watchdog abort, one-cycle response.
module avalon_lsu_master
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic              waitrequest,
  input  logic [31:0]       readdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = LSU_IDLE;
  localparam logic [1:0] S_READ  = LSU_READ;
  localparam logic [1:0] S_WRITE = LSU_WRITE;
  localparam logic [1:0] S_RESP  = LSU_RESP;

  logic [1:0]        state_r;
  mem_size_t         size_r;
  logic [1:0]        addr_lo_r;
  logic              signed_r;
  logic [CNT_W-1:0]  wd_cnt_r;

  logic              req_ready_r;
  logic              resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic [1:0]        resp_err_r;
  logic [ADDR_W-1:0] address_r;
  logic              read_r;
  logic              write_r;
  logic [3:0]        byteenable_r;
  logic [31:0]       writedata_r;

  mem_size_t         size_sel_s;
  logic [1:0]        addr_lo_sel_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic              misaligned_s;
  logic [31:0]       load_data_s;
  logic              wd_expired_s;

  // The aligner checks the incoming request while idle and extracts loads from the latched request otherwise
  always_comb begin
    size_sel_s    = size_r;
    addr_lo_sel_s = addr_lo_r;
    if (state_r == S_IDLE) begin
      size_sel_s    = mem_size_t'(req_size);
      addr_lo_sel_s = req_addr[1:0];
    end else begin
      size_sel_s    = size_r;
      addr_lo_sel_s = addr_lo_r;
    end
  end

  lsu_lane_align u_align (
    .size        (size_sel_s),
    .addr_lo     (addr_lo_sel_s),
    .load_signed (signed_r),
    .wdata       (req_wdata),
    .readdata    (readdata),
    .byteenable  (be_s),
    .writedata   (wdata_s),
    .misaligned  (misaligned_s),
    .load_data   (load_data_s)
  );

  assign wd_expired_s = (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Request FSM, bus strobes, watchdog and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      size_r       <= MEM_BYTE;
      addr_lo_r    <= 2'b00;
      signed_r     <= 1'b0;
      wd_cnt_r     <= '0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= LSU_ERR_OK;
      address_r    <= '0;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      byteenable_r <= 4'b0000;
      writedata_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          resp_valid_r <= 1'b0;
          if (req_valid) begin
            size_r      <= mem_size_t'(req_size);
            addr_lo_r   <= req_addr[1:0];
            signed_r    <= req_signed;
            wd_cnt_r    <= '0;
            req_ready_r <= 1'b0;
            if (misaligned_s) begin
              state_r      <= S_RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= LSU_ERR_ALIGN;
            end else begin
              state_r      <= req_write ? S_WRITE : S_READ;
              address_r    <= {req_addr[ADDR_W-1:2], 2'b00};
              byteenable_r <= be_s;
              writedata_r  <= wdata_s;
              read_r       <= ~req_write;
              write_r      <= req_write;
            end
          end
        end
        S_READ, S_WRITE: begin
          if (!waitrequest || wd_expired_s) begin
            if (!waitrequest) begin
              resp_err_r <= LSU_ERR_OK;
              if (state_r == S_READ) begin
                resp_rdata_r <= load_data_s;
              end
            end else begin
              resp_err_r <= LSU_ERR_TIMEOUT;
            end
            state_r      <= S_RESP;
            resp_valid_r <= 1'b1;
            read_r       <= 1'b0;
            write_r      <= 1'b0;
            byteenable_r <= 4'b0000;
          end else begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1);
          end
        end
        S_RESP: begin
          resp_valid_r <= 1'b0;
          req_ready_r  <= 1'b1;
          state_r      <= S_IDLE;
        end
        default: begin
          state_r      <= S_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          read_r       <= 1'b0;
          write_r      <= 1'b0;
          byteenable_r <= 4'b0000;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign address    = address_r;
  assign read       = read_r;
  assign write      = write_r;
  assign byteenable = byteenable_r;
  assign writedata  = writedata_r;

endmodule
